// File: rtl/video_timing_pkg.sv
// 720p60 raster timing constants and helpers.
// The sprite generators derive SCREEN_WIDTH/SCREEN_HEIGHT from the same constants.
package video_timing_pkg;
    localparam int ACTIVE_H = 1280;
    localparam int H_FP     = 110;
    localparam int H_SYNC   = 40;
    localparam int H_BP     = 220;
    localparam int ACTIVE_V = 720;
    localparam int V_FP     = 5;
    localparam int V_SYNC   = 5;
    localparam int V_BP     = 20;
    localparam int TOTAL_H  = ACTIVE_H + H_FP + H_SYNC + H_BP;
    localparam int TOTAL_V  = ACTIVE_V + V_FP + V_SYNC + V_BP;

    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;
    localparam int FC_W     = 6;

    typedef struct packed {
        logic hs;
        logic vs;
        logic ad;
    } sync_t;

    // Half-open window test: lo <= cnt < hi.
    function automatic logic in_window(input int cnt, input int lo, input int hi);
        return (cnt >= lo) && (cnt < hi);
    endfunction
endpackage

// File: rtl/video_sig_gen_pipe.sv
// Fixed-latency shift register with async active-low reset.
// STAGES=0 gives a plain combinational pass-through.
module pipe #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    if (STAGES == 0) begin : g_pass
        logic w_unused;
        assign w_unused = &{1'b0, i_clk, i_rst_n};
        assign o_q      = i_d;
    end else begin : g_shift
        logic [WIDTH-1:0] r_stage [STAGES];

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                for (int i = 0; i < STAGES; i++) begin
                    r_stage[i] <= '0;
                end
            end else begin
                r_stage[0] <= i_d;
                for (int i = 1; i < STAGES; i++) begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end

        assign o_q = r_stage[STAGES-1];
    end
endmodule

// File: rtl/video_sig_gen.sv
// Raster timing generator: registered hcount/vcount, syncs, active-draw, new-frame pulse and
// frame counter, plus a delayed hs/vs/ad copy that lines up with pipelined pixel generators.
module video_sig_gen
    import video_timing_pkg::*;
#(
    parameter int ACTIVE_H   = video_timing_pkg::ACTIVE_H,
    parameter int H_FP       = video_timing_pkg::H_FP,
    parameter int H_SYNC     = video_timing_pkg::H_SYNC,
    parameter int H_BP       = video_timing_pkg::H_BP,
    parameter int ACTIVE_V   = video_timing_pkg::ACTIVE_V,
    parameter int V_FP       = video_timing_pkg::V_FP,
    parameter int V_SYNC     = video_timing_pkg::V_SYNC,
    parameter int V_BP       = video_timing_pkg::V_BP,
    parameter int FPS        = 60,
    parameter int SYNC_DELAY = 2
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    output logic [HCOUNT_W-1:0] hcount_out,
    output logic [VCOUNT_W-1:0] vcount_out,
    output logic                hs_out,
    output logic                vs_out,
    output logic                ad_out,
    output logic                nf_out,
    output logic [FC_W-1:0]     fc_out,
    output logic                hs_dly_out,
    output logic                vs_dly_out,
    output logic                ad_dly_out
);
    localparam int TOTAL_H = ACTIVE_H + H_FP + H_SYNC + H_BP;
    localparam int TOTAL_V = ACTIVE_V + V_FP + V_SYNC + V_BP;

    if (TOTAL_H > 2048 || TOTAL_H > (1 << HCOUNT_W)) begin : g_bad_total_h
        $error("video_sig_gen: TOTAL_H=%0d does not fit the hcount width", TOTAL_H);
    end
    if (TOTAL_V > 1024 || TOTAL_V > (1 << VCOUNT_W)) begin : g_bad_total_v
        $error("video_sig_gen: TOTAL_V=%0d does not fit the vcount width", TOTAL_V);
    end
    if (FPS < 1 || FPS > (1 << FC_W)) begin : g_bad_fps
        $error("video_sig_gen: FPS=%0d does not fit the frame counter", FPS);
    end

    logic [HCOUNT_W-1:0] r_h_cnt;
    logic [VCOUNT_W-1:0] r_v_cnt;
    logic [HCOUNT_W-1:0] r_hcount;
    logic [VCOUNT_W-1:0] r_vcount;
    logic                r_hs, r_vs, r_ad, r_nf;
    logic [FC_W-1:0]     r_fc;
    logic                w_h_wrap, w_v_wrap, w_hs, w_vs, w_ad, w_nf;
    sync_t               w_sync, w_sync_dly;

    assign w_h_wrap = (r_h_cnt == HCOUNT_W'(TOTAL_H - 1));
    assign w_v_wrap = (r_v_cnt == VCOUNT_W'(TOTAL_V - 1));

    // Flags are decoded from the same counter value that is registered onto hcount/vcount,
    // so each output cycle is a self-consistent tuple.
    assign w_hs = in_window(int'(r_h_cnt), ACTIVE_H + H_FP, ACTIVE_H + H_FP + H_SYNC);
    assign w_vs = in_window(int'(r_v_cnt), ACTIVE_V + V_FP, ACTIVE_V + V_FP + V_SYNC);
    assign w_ad = in_window(int'(r_h_cnt), 0, ACTIVE_H) && in_window(int'(r_v_cnt), 0, ACTIVE_V);
    assign w_nf = (r_h_cnt == HCOUNT_W'(ACTIVE_H)) && (r_v_cnt == VCOUNT_W'(ACTIVE_V));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + 1'b1;
            if (w_h_wrap) begin
                r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_hcount <= '0;
            r_vcount <= '0;
            r_hs     <= 1'b0;
            r_vs     <= 1'b0;
            r_ad     <= 1'b0;
            r_nf     <= 1'b0;
            r_fc     <= '0;
        end else begin
            r_hcount <= r_h_cnt;
            r_vcount <= r_v_cnt;
            r_hs     <= w_hs;
            r_vs     <= w_vs;
            r_ad     <= w_ad;
            r_nf     <= w_nf;
            if (w_nf) begin
                r_fc <= (r_fc == FC_W'(FPS - 1)) ? '0 : r_fc + 1'b1;
            end
        end
    end

    assign w_sync = '{hs: r_hs, vs: r_vs, ad: r_ad};

    pipe #(
        .WIDTH  ($bits(sync_t)),
        .STAGES (SYNC_DELAY)
    ) u_sync_pipe (
        .i_clk   (clk_in),
        .i_rst_n (rst_n_in),
        .i_d     (w_sync),
        .o_q     (w_sync_dly)
    );

    assign hcount_out = r_hcount;
    assign vcount_out = r_vcount;
    assign hs_out     = r_hs;
    assign vs_out     = r_vs;
    assign ad_out     = r_ad;
    assign nf_out     = r_nf;
    assign fc_out     = r_fc;
    assign hs_dly_out = w_sync_dly.hs;
    assign vs_dly_out = w_sync_dly.vs;
    assign ad_dly_out = w_sync_dly.ad;
endmodule

// File: tb/tb_video_sig_gen.sv
// Bench for video_sig_gen: a default 720p instance for line timing, plus two shrunk rasters
// (15x8, FPS=4; SYNC_DELAY 2 and 0) so whole frames, fc wrap and mid-frame reset fit a short run.
`timescale 1ns/1ps
module tb_video_sig_gen;
    localparam int FRAME = 120;

    typedef struct packed {
        logic [10:0] h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic        ad;
        logic        nf;
        logic [5:0]  fc;
        logic        hsd;
        logic        vsd;
        logic        add;
    } obs_t;
    typedef struct packed {
        logic [15:0] k;
        obs_t        o;
    } vec_t;
    localparam int VEC_W = $bits(vec_t);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [10:0] d_h, s_h, z_h;
    logic [9:0]  d_v, s_v, z_v;
    logic        d_hs, d_vs, d_ad, d_nf, d_hsd, d_vsd, d_add;
    logic        s_hs, s_vs, s_ad, s_nf, s_hsd, s_vsd, s_add;
    logic        z_hs, z_vs, z_ad, z_nf, z_hsd, z_vsd, z_add;
    logic [5:0]  d_fc, s_fc, z_fc;
    obs_t        d_obs, s_obs, z_obs;

    assign d_obs = {d_h, d_v, d_hs, d_vs, d_ad, d_nf, d_fc, d_hsd, d_vsd, d_add};
    assign s_obs = {s_h, s_v, s_hs, s_vs, s_ad, s_nf, s_fc, s_hsd, s_vsd, s_add};
    assign z_obs = {z_h, z_v, z_hs, z_vs, z_ad, z_nf, z_fc, z_hsd, z_vsd, z_add};

    video_sig_gen u_def (
        .clk_in (clk), .rst_n_in (rst_n),
        .hcount_out (d_h), .vcount_out (d_v), .hs_out (d_hs), .vs_out (d_vs),
        .ad_out (d_ad), .nf_out (d_nf), .fc_out (d_fc),
        .hs_dly_out (d_hsd), .vs_dly_out (d_vsd), .ad_dly_out (d_add)
    );

    video_sig_gen #(
        .ACTIVE_H (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .ACTIVE_V (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .FPS (4), .SYNC_DELAY (2)
    ) u_small (
        .clk_in (clk), .rst_n_in (rst_n),
        .hcount_out (s_h), .vcount_out (s_v), .hs_out (s_hs), .vs_out (s_vs),
        .ad_out (s_ad), .nf_out (s_nf), .fc_out (s_fc),
        .hs_dly_out (s_hsd), .vs_dly_out (s_vsd), .ad_dly_out (s_add)
    );

    video_sig_gen #(
        .ACTIVE_H (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .ACTIVE_V (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .FPS (4), .SYNC_DELAY (0)
    ) u_zero (
        .clk_in (clk), .rst_n_in (rst_n),
        .hcount_out (z_h), .vcount_out (z_v), .hs_out (z_hs), .vs_out (z_vs),
        .ad_out (z_ad), .nf_out (z_nf), .fc_out (z_fc),
        .hs_dly_out (z_hsd), .vs_dly_out (z_vsd), .ad_dly_out (z_add)
    );

    // ---------------- scoreboard ----------------
    logic [VEC_W-1:0] d_q[$];
    logic [VEC_W-1:0] s_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Expected tuple at the k-th rising edge after reset release (k=0 is the first).
    task automatic push(input bit to_def, input int k, input int h, input int v,
                        input logic hs, input logic vs, input logic ad, input logic nf,
                        input int fc, input logic hsd, input logic vsd, input logic add);
        vec_t e;
        e.k     = 16'(k);
        e.o.h   = 11'(h);
        e.o.v   = 10'(v);
        e.o.hs  = hs;
        e.o.vs  = vs;
        e.o.ad  = ad;
        e.o.nf  = nf;
        e.o.fc  = 6'(fc);
        e.o.hsd = hsd;
        e.o.vsd = vsd;
        e.o.add = add;
        if (to_def) d_q.push_back(e);
        else        s_q.push_back(e);
    endtask

    function automatic int head_k(input logic [VEC_W-1:0] raw);
        vec_t t;
        t = raw;
        return int'(t.k);
    endfunction

    // ---------------- monitor ----------------
    int k_cur       = -1;
    bit rst_checked = 1'b0;
    int phase       = 0;
    int last_nf     = -1;
    int def_hs_cnt = 0, def_ad_cnt = 0, s_vs_cnt = 0, s_ad_cnt = 0, s_nf_cnt = 0;
    int s_hmax = 0, s_vmax = 0;

    always @(negedge clk) begin : mon
        vec_t e;
        obs_t ez;
        if (!rst_n) begin
            k_cur   = -1;
            last_nf = -1;
            if (!rst_checked) begin
                rst_checked = 1'b1;
                chk("rst_def_zero",   64'(d_obs), 64'(0));
                chk("rst_small_zero", 64'(s_obs), 64'(0));
                chk("rst_sd0_zero",   64'(z_obs), 64'(0));
            end
        end else begin
            rst_checked = 1'b0;
            k_cur = k_cur + 1;
            while (d_q.size() > 0 && head_k(d_q[0]) <= k_cur) begin
                e = d_q.pop_front();
                if (int'(e.k) != k_cur) chk("def_missed_vec", 64'(k_cur), 64'(e.k));
                else chk($sformatf("def_k%0d", k_cur), 64'(d_obs), 64'(e.o));
            end
            while (s_q.size() > 0 && head_k(s_q[0]) <= k_cur) begin
                e = s_q.pop_front();
                if (int'(e.k) != k_cur) begin
                    chk("small_missed_vec", 64'(k_cur), 64'(e.k));
                end else begin
                    ez     = e.o;
                    ez.hsd = e.o.hs;
                    ez.vsd = e.o.vs;
                    ez.add = e.o.ad;
                    chk($sformatf("small_k%0d", k_cur), 64'(s_obs), 64'(e.o));
                    chk($sformatf("sd0_k%0d", k_cur),   64'(z_obs), 64'(ez));
                end
            end
            if (phase == 1) begin
                if (k_cur < 1650) begin
                    def_hs_cnt += int'(d_hs);
                    def_ad_cnt += int'(d_ad);
                end
                if (k_cur < FRAME) begin
                    s_vs_cnt += int'(s_vs);
                    s_ad_cnt += int'(s_ad);
                end
                if (int'(s_h) > s_hmax) s_hmax = int'(s_h);
                if (int'(s_v) > s_vmax) s_vmax = int'(s_v);
                if (s_nf) begin
                    s_nf_cnt++;
                    if (last_nf >= 0) chk("nf_period", 64'(k_cur - last_nf), 64'(FRAME));
                    last_nf = k_cur;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // default 720p: line 0 edges, hsync window, h wrap into line 1
        //    def k     h     v  hs vs ad nf fc hsd vsd add
        push(1, 0,    0,    0, 0, 0, 1, 0, 0, 0, 0, 0);
        push(1, 1279, 1279, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        push(1, 1280, 1280, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        push(1, 1282, 1282, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(1, 1389, 1389, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(1, 1390, 1390, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        push(1, 1392, 1392, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        push(1, 1429, 1429, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        push(1, 1430, 1430, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        push(1, 1432, 1432, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(1, 1649, 1649, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(1, 1650, 0,    1, 0, 0, 1, 0, 0, 0, 0, 0);
        push(1, 1652, 2,    1, 0, 0, 1, 0, 0, 0, 0, 1);
        // shrunk raster 15x8: hs 10..12, vs lines 5..6, nf at (8,4), FPS 4
        push(0, 0,    0,  0, 0, 0, 1, 0, 0, 0, 0, 0);
        push(0, 1,    1,  0, 0, 0, 1, 0, 0, 0, 0, 0);
        push(0, 2,    2,  0, 0, 0, 1, 0, 0, 0, 0, 1);
        push(0, 7,    7,  0, 0, 0, 1, 0, 0, 0, 0, 1);
        push(0, 8,    8,  0, 0, 0, 0, 0, 0, 0, 0, 1);
        push(0, 9,    9,  0, 0, 0, 0, 0, 0, 0, 0, 1);
        push(0, 10,   10, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        push(0, 12,   12, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        push(0, 13,   13, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        push(0, 14,   14, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        push(0, 15,   0,  1, 0, 0, 1, 0, 0, 0, 0, 0);
        push(0, 17,   2,  1, 0, 0, 1, 0, 0, 0, 0, 1);
        push(0, 67,   7,  4, 0, 0, 0, 0, 0, 0, 0, 0);
        push(0, 68,   8,  4, 0, 0, 0, 1, 1, 0, 0, 0);
        push(0, 69,   9,  4, 0, 0, 0, 0, 1, 0, 0, 0);
        push(0, 75,   0,  5, 0, 1, 0, 0, 1, 0, 0, 0);
        push(0, 77,   2,  5, 0, 1, 0, 0, 1, 0, 1, 0);
        push(0, 100,  10, 6, 1, 1, 0, 0, 1, 0, 1, 0);
        push(0, 102,  12, 6, 1, 1, 0, 0, 1, 1, 1, 0);
        push(0, 105,  0,  7, 0, 0, 0, 0, 1, 0, 1, 0);
        push(0, 107,  2,  7, 0, 0, 0, 0, 1, 0, 0, 0);
        push(0, 119,  14, 7, 0, 0, 0, 0, 1, 1, 0, 0);
        push(0, 120,  0,  0, 0, 0, 1, 0, 1, 0, 0, 0);
        push(0, 122,  2,  0, 0, 0, 1, 0, 1, 0, 0, 1);
        push(0, 188,  8,  4, 0, 0, 0, 1, 2, 0, 0, 0);
        push(0, 308,  8,  4, 0, 0, 0, 1, 3, 0, 0, 0);
        push(0, 428,  8,  4, 0, 0, 0, 1, 0, 0, 0, 0);
        push(0, 429,  9,  4, 0, 0, 0, 0, 0, 0, 0, 0);
        push(0, 548,  8,  4, 0, 0, 0, 1, 1, 0, 0, 0);
        push(0, 1700, 5,  1, 0, 0, 1, 0, 2, 0, 0, 1);

        phase = 1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (1703) @(negedge clk);

        chk("def_hs_cycles_line0", 64'(def_hs_cnt), 64'(40));
        chk("def_ad_cycles_line0", 64'(def_ad_cnt), 64'(1280));
        chk("small_vs_cycles_f0",  64'(s_vs_cnt),   64'(30));
        chk("small_ad_cycles_f0",  64'(s_ad_cnt),   64'(32));
        chk("small_nf_pulses",     64'(s_nf_cnt),   64'(14));
        chk("small_hcount_max",    64'(s_hmax),     64'(14));
        chk("small_vcount_max",    64'(s_vmax),     64'(7));
        chk("def_q_drained_p1",    64'(d_q.size()), 64'(0));
        chk("small_q_drained_p1",  64'(s_q.size()), 64'(0));

        // mid-frame asynchronous reset, asserted between clock edges
        phase = 2;
        @(posedge clk);
        #3 rst_n = 1'b0;
        push(1, 0,  0,  0, 0, 0, 1, 0, 0, 0, 0, 0);
        push(1, 1,  1,  0, 0, 0, 1, 0, 0, 0, 0, 0);
        push(1, 2,  2,  0, 0, 0, 1, 0, 0, 0, 0, 1);
        push(0, 0,  0,  0, 0, 0, 1, 0, 0, 0, 0, 0);
        push(0, 1,  1,  0, 0, 0, 1, 0, 0, 0, 0, 0);
        push(0, 2,  2,  0, 0, 0, 1, 0, 0, 0, 0, 1);
        push(0, 67, 7,  4, 0, 0, 0, 0, 0, 0, 0, 0);
        push(0, 68, 8,  4, 0, 0, 0, 1, 1, 0, 0, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (200) @(negedge clk);

        chk("def_q_drained_p2",   64'(d_q.size()), 64'(0));
        chk("small_q_drained_p2", 64'(s_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/video_sig_gen.md
Name: video_sig_gen

Overview:
- Raster timing generator: the producer side of the hcount/vcount pixel interface that every sprite/screen generator in the game consumes.
- Drives hcount/vcount, active-draw, hsync/vsync, a new-frame pulse and a frame counter for 1280x720@60 (74.25 MHz pixel clock).
- Provides a delayed copy of hsync, vsync and active-draw so the HDMI/TMDS stage lines up with pixel generators that have pipeline latency.

Parameters:
- ACTIVE_H, 1280, visible pixels per line
- H_FP, 110, horizontal front porch, pixels
- H_SYNC, 40, horizontal sync width, pixels
- H_BP, 220, horizontal back porch, pixels
- ACTIVE_V, 720, visible lines per frame
- V_FP, 5, vertical front porch, lines
- V_SYNC, 5, vertical sync width, lines
- V_BP, 20, vertical back porch, lines
- FPS, 60, frame counter modulus
- SYNC_DELAY, 2, cycles of extra delay on hs/vs/ad delayed outputs (0 allowed)

Ports:
- clk_in  input  1  pixel clock
- rst_n_in  input  1  asynchronous, active-low reset
- hcount_out  output  11  horizontal position, 0..TOTAL_H-1
- vcount_out  output  10  vertical position, 0..TOTAL_V-1
- hs_out  output  1  horizontal sync, active high
- vs_out  output  1  vertical sync, active high
- ad_out  output  1  active draw; 1 when hcount_out<ACTIVE_H and vcount_out<ACTIVE_V
- nf_out  output  1  single-cycle new-frame pulse
- fc_out  output  6  frame count, 0..FPS-1
- hs_dly_out  output  1  hs_out delayed SYNC_DELAY cycles
- vs_dly_out  output  1  vs_out delayed SYNC_DELAY cycles
- ad_dly_out  output  1  ad_out delayed SYNC_DELAY cycles

Behaviour:
- Derived constants:
  - TOTAL_H = ACTIVE_H+H_FP+H_SYNC+H_BP (1650)
  - TOTAL_V = ACTIVE_V+V_FP+V_SYNC+V_BP (750)
- Internal counters h_cnt/v_cnt:
  - h_cnt increments every cycle and wraps TOTAL_H-1 -> 0.
  - v_cnt increments only on h wrap and wraps TOTAL_V-1 -> 0 on the same edge.
- All outputs are registered, with one cycle of latency from the internal counters. Each cycle's output tuple is self-consistent: the flags are decoded from the same count shown on hcount_out/vcount_out.
- hs_out = 1 iff ACTIVE_H+H_FP <= hcount_out < ACTIVE_H+H_FP+H_SYNC (1390..1429).
- vs_out = 1 iff ACTIVE_V+V_FP <= vcount_out < ACTIVE_V+V_FP+V_SYNC (725..729), for every hcount on those lines.
- nf_out = 1 for exactly one cycle, when hcount_out==ACTIVE_H and vcount_out==ACTIVE_V (the first blanking pixel after the last visible pixel).
- fc_out increments in the same cycle nf_out asserts and wraps FPS-1 -> 0.
- Reset (rst_n_in low, asynchronous):
  - Counters clear to 0.
  - hcount_out, vcount_out, hs_out, vs_out, ad_out, nf_out, fc_out and all *_dly_out clear to 0. ad_out is 0 during reset even though the count is 0,0.
  - Deassertion is taken synchronously. On the first rising edge with rst_n_in high, outputs show hcount=0, vcount=0, ad=1, and the counter advances to 1.
  - Reset mid-frame abandons the frame: no nf_out pulse, fc_out returns to 0.
- Delay line:
  - SYNC_DELAY-stage shift register per signal, reset to 0.
  - With SYNC_DELAY=0, *_dly_out equal the undelayed outputs combinationally.
- Boundaries:
  - hcount_out never shows TOTAL_H; vcount_out never shows TOTAL_V.
  - Simultaneous h and v wrap (1649,749 -> 0,0) is a single-cycle transition with no skipped line.
- Widths: the counters must hold TOTAL_H-1 and TOTAL_V-1. For the defaults, 11 and 10 bits suffice. Elaboration-time check that TOTAL_H <= 2048 and TOTAL_V <= 1024.

Decomposition:
- Package video_timing_pkg holds:
  - 720p localparams: ACTIVE_H, H_FP, H_SYNC, H_BP, ACTIVE_V, V_FP, V_SYNC, V_BP, TOTAL_H, TOTAL_V
  - HCOUNT_W=11, VCOUNT_W=10
  - These are shared with the sprite generators' SCREEN_WIDTH/SCREEN_HEIGHT.
- One sub-module: pipe (parameters WIDTH, STAGES; async active-low reset), instanced once with WIDTH=3 for {hs, vs, ad}.

Test Plan:
- Reset release -> first valid cycle shows hcount=0, vcount=0, ad=1, hs=0, vs=0, nf=0, fc=0. Every output reads 0 while rst_n_in is low.
- Run one line -> ad=1 for hcount 0..1279 and 0 for 1280..1649. hs high for exactly 40 cycles starting at hcount 1390. hcount wraps 1649 -> 0 with vcount 0 -> 1.
- Run one full frame (1,237,500 cycles) -> vs high exactly on lines 725..729 (5x1650 cycles). nf pulses once at (1280,720). fc 0 -> 1. The tuple (1649,749) is followed by (0,0).
- Run 60 frames -> fc counts 0..59 and wraps to 0 on the 60th nf pulse. The nf period is exactly 1,237,500 cycles.
- Assert rst_n_in asynchronously (mid-clock) at hcount=500, vcount=300 -> outputs go to 0 immediately with no clock edge. After release, counting restarts at (0,0) with fc=0.
- SYNC_DELAY=2 and SYNC_DELAY=0 builds -> hs/vs/ad_dly_out equal hs/vs/ad_out shifted by exactly 2 cycles (or 0 cycles), including across reset.
